branch_predictor_btb: RTL and testbench

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the IF stage of the 5-stage MIPS pipeline. The IF stage looks up the fetch PC combinationally and gets a taken/target prediction. The resolving stage (EX/MEM) writes the actual outcome back one update per cycle. MODE selects bimodal or gshare indexing. The block also keeps a non-speculative global history register and a saturating mispredict counter for the cpu tracker.

---
 rtl/branch_predictor_btb_if.sv | 30 +++
 rtl/branch_predictor_btb.sv | 108 ++++++++++
 tb/tb_branch_predictor_btb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and resolve-side update bundle for the branch target buffer.
// upd_en acts as a valid with no ready: the BTB accepts every update in the cycle it is presented.
interface branch_predictor_btb_if #(
  parameter int HIST_W = 4,
  parameter int CNT_W  = 16
);
  logic [31:0]       lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic [HIST_W-1:0] pred_ghr;
  logic              upd_en;
  logic [31:0]       upd_pc;
  logic [HIST_W-1:0] upd_ghr;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_mispred;
  logic [HIST_W-1:0] ghr;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output lookup_pc, upd_en, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispred,
    input  pred_hit, pred_taken, pred_target, pred_ghr, ghr, mispred_cnt
  );

  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispred,
    output pred_hit, pred_taken, pred_target, pred_ghr, ghr, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters, bimodal or gshare indexing,
// a non-speculative global history register and a saturating mispredict counter.
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int MODE    = 0,
  parameter int HIST_W  = 4,
  parameter int CNT_W   = 16
) (
  input logic                  CLK,
  input logic                  RST,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic               r_valid  [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];
  logic [HIST_W-1:0]  r_ghr;
  logic [CNT_W-1:0]   r_mcnt;

  logic [IDX_W-1:0]   w_lk_hist;
  logic [IDX_W-1:0]   w_up_hist;
  logic [IDX_W-1:0]   w_lk_idx;
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_lk_hit;
  logic               w_lk_taken;
  logic               w_up_hit;
  logic [1:0]         w_cnt_cur;
  logic [1:0]         w_cnt_next;
  logic [HIST_W-1:0]  w_ghr_next;
  logic               w_unused;

  assign w_unused = ^bus.upd_pc[1:0];

  // Updates index with the history the branch was predicted with, not the live GHR.
  assign w_lk_hist = (MODE == 1) ? IDX_W'(r_ghr)       : '0;
  assign w_up_hist = (MODE == 1) ? IDX_W'(bus.upd_ghr) : '0;
  assign w_lk_idx  = bus.lookup_pc[IDX_W+1:2] ^ w_lk_hist;
  assign w_up_idx  = bus.upd_pc[IDX_W+1:2]    ^ w_up_hist;
  assign w_lk_tag  = bus.lookup_pc[31:IDX_W+2];
  assign w_up_tag  = bus.upd_pc[31:IDX_W+2];

  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_cnt[w_lk_idx][1];

  assign bus.pred_hit    = w_lk_hit;
  assign bus.pred_taken  = w_lk_taken;
  assign bus.pred_target = w_lk_taken ? r_target[w_lk_idx] : bus.lookup_pc + 32'd4;
  assign bus.pred_ghr    = r_ghr;
  assign bus.ghr         = r_ghr;
  assign bus.mispred_cnt = r_mcnt;

  assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_cnt_cur = r_cnt[w_up_idx];

  always_comb begin
    w_cnt_next = w_cnt_cur;
    if (bus.upd_taken) begin
      if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'd1;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'd1;
    end
  end

  generate
    if (HIST_W == 1) begin : g_hist1
      assign w_ghr_next = bus.upd_taken;
    end else begin : g_histn
      assign w_ghr_next = {r_ghr[HIST_W-2:0], bus.upd_taken};
    end
  endgenerate

  // Tag hit trains the counter; a taken miss allocates at weak-taken; a not-taken miss is ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= 2'b01;
      end
    end else if (bus.upd_en) begin
      if (w_up_hit) begin
        r_cnt[w_up_idx] <= w_cnt_next;
        if (bus.upd_taken) r_target[w_up_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bus.upd_target;
        r_cnt[w_up_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ghr  <= '0;
      r_mcnt <= '0;
    end else if (bus.upd_en) begin
      r_ghr <= w_ghr_next;
      if (bus.upd_mispred && (r_mcnt != '1)) r_mcnt <= r_mcnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench: bimodal table vectors, gshare indexing/history sequence,
// and mispredict counter saturation with asynchronous reset on a narrow counter.
module tb_branch_predictor_btb;
  logic CLK;
  logic rst;
  logic rst2;
  int   checks;
  int   errors;

  branch_predictor_btb_if #(.HIST_W(4), .CNT_W(16)) if0 ();
  branch_predictor_btb_if #(.HIST_W(4), .CNT_W(16)) if1 ();
  branch_predictor_btb_if #(.HIST_W(4), .CNT_W(2))  if2 ();

  branch_predictor_btb #(.ENTRIES(16), .MODE(0), .HIST_W(4), .CNT_W(16)) dut0 (
    .CLK(CLK), .RST(rst), .bus(if0.slave));
  branch_predictor_btb #(.ENTRIES(16), .MODE(1), .HIST_W(4), .CNT_W(16)) dut1 (
    .CLK(CLK), .RST(rst), .bus(if1.slave));
  branch_predictor_btb #(.ENTRIES(16), .MODE(0), .HIST_W(4), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(rst2), .bus(if2.slave));

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] lk;
    logic        en;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        hit;
    logic        ptk;
    logic [31:0] ptgt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [31:0] lk, logic en, logic [31:0] pc, logic tk,
                              logic [31:0] tgt, logic hit, logic ptk, logic [31:0] ptgt);
    vec_t v;
    v.lk = lk; v.en = en; v.pc = pc; v.tk = tk; v.tgt = tgt;
    v.hit = hit; v.ptk = ptk; v.ptgt = ptgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive1(input logic en, input logic [31:0] pc, input logic [3:0] g,
                        input logic tk, input logic [31:0] tgt);
    if1.upd_en = en; if1.upd_pc = pc; if1.upd_ghr = g;
    if1.upd_taken = tk; if1.upd_target = tgt;
  endtask

  task automatic drive2(input logic en, input logic mp);
    if2.upd_en = en; if2.upd_mispred = mp;
    if2.upd_pc = 32'h40; if2.upd_ghr = '0; if2.upd_taken = 1'b1; if2.upd_target = 32'h100;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    rst2 = 1'b1;
    if0.lookup_pc = 32'h40; if0.upd_en = 1'b0; if0.upd_pc = '0; if0.upd_ghr = '0;
    if0.upd_taken = 1'b0; if0.upd_target = '0; if0.upd_mispred = 1'b0;
    if1.lookup_pc = 32'h40; if1.upd_mispred = 1'b0;
    drive1(1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    if2.lookup_pc = 32'h40;
    drive2(1'b0, 1'b0);

    // Bimodal table: expected outputs are what the lookup sees before that row's update.
    vecs[0]  = mk(32'h40,       1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44);
    vecs[1]  = mk(32'hFFFFFFFC, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h0);
    vecs[2]  = mk(32'h40,       1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h44);
    vecs[3]  = mk(32'h40,       1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 1'b1, 32'h100);
    vecs[4]  = mk(32'h80,       1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h84);
    vecs[5]  = mk(32'h40,       1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100);
    vecs[6]  = mk(32'h40,       1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 1'b0, 32'h44);
    vecs[7]  = mk(32'h40,       1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 1'b0, 32'h44);
    vecs[8]  = mk(32'h40,       1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 32'h44);
    vecs[9]  = mk(32'h40,       1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 32'h44);
    vecs[10] = mk(32'h40,       1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 1'b1, 32'h100);
    vecs[11] = mk(32'h40,       1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200);
    vecs[12] = mk(32'h40,       1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200);
    vecs[13] = mk(32'h40,       1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 1'b1, 32'h200);
    vecs[14] = mk(32'h80,       1'b1, 32'h80, 1'b0, 32'h0,   1'b0, 1'b0, 32'h84);
    vecs[15] = mk(32'h80,       1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h84);
    vecs[16] = mk(32'h80,       1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 1'b0, 32'h84);
    vecs[17] = mk(32'h80,       1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 1'b1, 32'h300);
    vecs[18] = mk(32'h40,       1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h44);
    vecs[19] = mk(32'h44,       1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 32'h48);

    repeat (2) @(negedge CLK);
    rst  = 1'b0;
    rst2 = 1'b0;
    #1;
    chk("reset_ghr0", 32'(if0.ghr), 32'h0);
    chk("reset_mcnt0", 32'(if0.mispred_cnt), 32'h0);
    chk("reset_pred_ghr0", 32'(if0.pred_ghr), 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      if0.lookup_pc  = vecs[i].lk;
      if0.upd_en     = vecs[i].en;
      if0.upd_pc     = vecs[i].pc;
      if0.upd_taken  = vecs[i].tk;
      if0.upd_target = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d_hit", i),    32'(if0.pred_hit),   32'(vecs[i].hit));
      chk($sformatf("v%0d_taken", i),  32'(if0.pred_taken), 32'(vecs[i].ptk));
      chk($sformatf("v%0d_target", i), if0.pred_target,     vecs[i].ptgt);
    end
    @(negedge CLK);
    if0.upd_en = 1'b0;

    // Gshare: update index comes from upd_ghr, lookup index from the live GHR.
    drive1(1'b1, 32'h40, 4'b0011, 1'b1, 32'h100);
    @(posedge CLK); #1;
    chk("gs_ghr_a", 32'(if1.ghr), 32'h1);
    @(negedge CLK);
    drive1(1'b1, 32'h1000, 4'b0000, 1'b1, 32'h500);
    @(posedge CLK); #1;
    chk("gs_ghr_b", 32'(if1.ghr), 32'h3);
    @(negedge CLK);
    drive1(1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    if1.lookup_pc = 32'h40;
    #1;
    chk("gs_pred_ghr3", 32'(if1.pred_ghr), 32'h3);
    chk("gs_hit_ghr3", 32'(if1.pred_hit), 32'h1);
    chk("gs_taken_ghr3", 32'(if1.pred_taken), 32'h1);
    chk("gs_target_ghr3", if1.pred_target, 32'h100);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      drive1(1'b1, 32'h2004, 4'h0, 1'b0, 32'h0);
    end
    @(negedge CLK);
    drive1(1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    #1;
    chk("gs_ghr_zero", 32'(if1.ghr), 32'h0);
    chk("gs_hit_ghr0", 32'(if1.pred_hit), 32'h0);
    chk("gs_target_ghr0", if1.pred_target, 32'h44);
    drive1(1'b1, 32'h2004, 4'h0, 1'b1, 32'h600);
    @(posedge CLK); #1;
    chk("gs_shift_t", 32'(if1.ghr), 32'h1);
    @(negedge CLK);
    drive1(1'b1, 32'h2004, 4'h0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    chk("gs_shift_nt", 32'(if1.ghr), 32'h2);
    @(negedge CLK);
    drive1(1'b1, 32'h2004, 4'h0, 1'b1, 32'h600);
    @(posedge CLK); #1;
    chk("gs_shift_t2", 32'(if1.ghr), 32'h5);
    @(negedge CLK);
    drive1(1'b0, 32'h0, 4'h0, 1'b0, 32'h0);

    // Narrow mispredict counter: ignored without upd_en, then saturates at 3.
    drive2(1'b0, 1'b1);
    @(posedge CLK); #1;
    chk("mc_no_en", 32'(if2.mispred_cnt), 32'h0);
    chk("mc_no_en_ghr", 32'(if2.ghr), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      drive2(1'b1, 1'b1);
      @(posedge CLK); #1;
      chk($sformatf("mc_step%0d", k), 32'(if2.mispred_cnt), (k < 3) ? k + 1 : 3);
    end
    chk("mc_ghr_f", 32'(if2.ghr), 32'hF);
    @(negedge CLK);
    drive2(1'b0, 1'b1);
    #1;
    chk("mc_hit_before_rst", 32'(if2.pred_hit), 32'h1);
    @(posedge CLK); #1;
    chk("mc_held", 32'(if2.mispred_cnt), 32'h3);
    #2;
    rst2 = 1'b1;
    #1;
    chk("arst_mcnt", 32'(if2.mispred_cnt), 32'h0);
    chk("arst_ghr", 32'(if2.ghr), 32'h0);
    chk("arst_hit", 32'(if2.pred_hit), 32'h0);
    chk("arst_target", if2.pred_target, 32'h44);
    @(negedge CLK);
    rst2 = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
